// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and binary32 ordering helpers.
// Used by the argmax classifier and the max-pool stage.
package cnn_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 32;
    localparam int IDX_W       = 4;

    typedef logic [DATA_W-1:0] fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } argmax_state_e;

    function automatic logic fp32_is_nan(input fp32_t x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Monotonic unsigned key: positives above negatives, negatives bit-inverted.
    function automatic logic [DATA_W-1:0] fp32_order_key(input fp32_t x);
        fp32_t v;
        v = (x == 32'h8000_0000) ? 32'h0000_0000 : x;
        return v[31] ? ~v : {1'b1, v[30:0]};
    endfunction

endpackage

// File: rtl/argmax_classifier_if.sv
// Score-in / class-out bus of the argmax classifier.
// ARGMAX_SCORE_OUT_EN adds the max_score return field.
interface argmax_classifier_if;
    import cnn_pkg::*;

    logic             input_valid;
    fp32_t            d_in [NUM_CLASSES-1:0];
    logic             busy;
    logic             output_valid;
    logic [IDX_W-1:0] class_out;
`ifdef ARGMAX_SCORE_OUT_EN
    fp32_t            max_score;

    modport master (output input_valid, d_in,
                    input  busy, output_valid, class_out, max_score);
    modport slave  (input  input_valid, d_in,
                    output busy, output_valid, class_out, max_score);
`else
    modport master (output input_valid, d_in,
                    input  busy, output_valid, class_out);
    modport slave  (input  input_valid, d_in,
                    output busy, output_valid, class_out);
`endif
endinterface

// File: rtl/fp32_greater.sv
// Combinational binary32 a > b; a NaN never wins, any number beats a NaN b.
module fp32_greater
    import cnn_pkg::*;
(
    input  fp32_t a_i,
    input  fp32_t b_i,
    output logic  gt_o
);
    always_comb begin
        gt_o = !fp32_is_nan(a_i) &&
               (fp32_is_nan(b_i) || (fp32_order_key(a_i) > fp32_order_key(b_i)));
    end
endmodule

// File: rtl/argmax_classifier.sv
// Sequential argmax over NUM_CLASSES binary32 scores, one compare per cycle.
// Optional ARGMAX_SCORE_OUT_EN also returns the winning score.
module argmax_classifier
    import cnn_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    argmax_classifier_if.slave  bus
);
    argmax_state_e    state_q, state_d;
    fp32_t            bank_q [NUM_CLASSES-1:0];
    fp32_t            best_val_q, best_val_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic [IDX_W-1:0] class_q;
    logic             out_vld_q;
    logic             busy, done, capture, last_cmp, cand_gt;
    fp32_t            cand;

    assign capture  = bus.input_valid && (state_q != ST_SCAN);
    assign cand     = bank_q[scan_idx_q];
    assign last_cmp = (scan_idx_q == IDX_W'(NUM_CLASSES - 1));

    fp32_greater u_gt (
        .a_i  (cand),
        .b_i  (best_val_q),
        .gt_o (cand_gt)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.input_valid) state_d = ST_SCAN;
            ST_SCAN: if (last_cmp)        state_d = ST_DONE;
            ST_DONE: state_d = bus.input_valid ? ST_SCAN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_SCAN);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        scan_idx_d = scan_idx_q;
        if (capture) begin
            best_val_d = bus.d_in[0];
            best_idx_d = '0;
            scan_idx_d = IDX_W'(1);
        end else if (busy) begin
            if (cand_gt) begin
                best_val_d = cand;
                best_idx_d = scan_idx_q;
            end
            // Park on the last index so the bank read never leaves range.
            if (!last_cmp) scan_idx_d = scan_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_val_q <= '0;
            best_idx_q <= '0;
            scan_idx_q <= '0;
            class_q    <= '0;
            out_vld_q  <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) bank_q[i] <= '0;
        end else begin
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            scan_idx_q <= scan_idx_d;
            out_vld_q  <= done;
            if (done) class_q <= best_idx_q;
            if (capture) begin
                for (int i = 0; i < NUM_CLASSES; i++) bank_q[i] <= bus.d_in[i];
            end
        end
    end

    assign bus.busy         = busy;
    assign bus.output_valid = out_vld_q;
    assign bus.class_out    = class_q;

`ifdef ARGMAX_SCORE_OUT_EN
    fp32_t score_q;

    always_ff @(posedge clk) begin
        if (rst)       score_q <= '0;
        else if (done) score_q <= best_val_q;
    end

    assign bus.max_score = score_q;
`endif
endmodule

// File: tb/tb_argmax_classifier.sv
// Directed + random bench for argmax_classifier against a real-valued argmax model.
// Define ARGMAX_SCORE_OUT_EN to also check max_score.
module tb_argmax_classifier;
    import cnn_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    argmax_classifier_if bus ();

    argmax_classifier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_nan(input fp32_t x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Numeric value of a binary32 pattern; infinities become +/-1e300.
    function automatic real to_real(input fp32_t x);
        real mag;
        int  e;
        real m;
        e = int'(x[30:23]);
        m = real'(x[22:0]);
        if (e == 255)    mag = 1.0e300;
        else if (e == 0) mag = m * (2.0 ** (-149));
        else             mag = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
        return x[31] ? -mag : mag;
    endfunction

    // First index of the numerically largest non-NaN score; 0 when all NaN.
    function automatic int ref_argmax(input fp32_t s [NUM_CLASSES]);
        int best = -1;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (!is_nan(s[i]) && (best < 0 || to_real(s[i]) > to_real(s[best]))) best = i;
        end
        return (best < 0) ? 0 : best;
    endfunction

    task automatic drive(input fp32_t s [NUM_CLASSES]);
        for (int i = 0; i < NUM_CLASSES; i++) bus.d_in[i] = s[i];
        bus.input_valid = 1'b1;
    endtask

    task automatic run_frame(input string tag, input fp32_t s [NUM_CLASSES], input int exp_cls);
        int    rc;
        int    first_ov = -1;
        int    nov = 0;
        int    nbusy = 0;
        logic [IDX_W-1:0] cls_at_ov = '0;
        fp32_t score_at_ov = '0;
        rc = ref_argmax(s);
        @(negedge clk);
        drive(s);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            bus.input_valid = 1'b0;
            if (bus.busy) nbusy++;
            if (bus.output_valid) begin
                nov++;
                if (first_ov < 0) begin
                    first_ov  = c;
                    cls_at_ov = bus.class_out;
`ifdef ARGMAX_SCORE_OUT_EN
                    score_at_ov = bus.max_score;
`endif
                end
            end
        end
        chk({tag, ".latency"}, 32'(first_ov), 32'd11);
        chk({tag, ".pulses"},  32'(nov),      32'd1);
        chk({tag, ".busy"},    32'(nbusy),    32'd9);
        chk({tag, ".class"},   32'(cls_at_ov), 32'(rc));
        chk({tag, ".held"},    32'(bus.class_out), 32'(rc));
        if (exp_cls >= 0) chk({tag, ".spec"}, 32'(cls_at_ov), 32'(exp_cls));
`ifdef ARGMAX_SCORE_OUT_EN
        chk({tag, ".score"}, score_at_ov, s[rc]);
`else
        if (score_at_ov !== '0) chk({tag, ".noscore"}, score_at_ov, 32'd0);
`endif
    endtask

    function automatic fp32_t rand_score();
        int    mode;
        fp32_t pool [4];
        pool = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 32'h3F00_0000};
        mode = $urandom_range(0, 9);
        case (mode)
            0:       return {1'($urandom), 8'hFF, 23'h40_0000 | 23'($urandom)};
            1:       return {1'($urandom), 8'hFF, 23'd0};
            2:       return {1'($urandom), 31'd0};
            3, 4:    return pool[$urandom_range(0, 3)];
            default: return {1'($urandom), 8'($urandom_range(0, 254)), 23'($urandom)};
        endcase
    endfunction

    fp32_t tenths [NUM_CLASSES] = '{32'h3DCC_CCCD, 32'h3E4C_CCCD, 32'h3E99_999A, 32'h3ECC_CCCD,
                                    32'h3F00_0000, 32'h3F19_999A, 32'h3F33_3333, 32'h3F4C_CCCD,
                                    32'h3F66_6666, 32'h3F80_0000};

    initial begin
        fp32_t s [NUM_CLASSES];
        fp32_t t [NUM_CLASSES];
        int    nov;
        int    ov_at [2];

        rst = 1'b1;
        bus.input_valid = 1'b0;
        for (int i = 0; i < NUM_CLASSES; i++) bus.d_in[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy",  32'(bus.busy),         32'd0);
        chk("reset.ovld",  32'(bus.output_valid), 32'd0);
        chk("reset.class", 32'(bus.class_out),    32'd0);
`ifdef ARGMAX_SCORE_OUT_EN
        chk("reset.score", bus.max_score, 32'd0);
`endif
        rst = 1'b0;

        run_frame("ascend", tenths, 9);

        for (int i = 0; i < NUM_CLASSES; i++) s[i] = 32'hBF80_0000;
        s[3] = 32'hBF00_0000;
        run_frame("neg", s, 3);

        for (int i = 0; i < NUM_CLASSES; i++) s[i] = 32'h3F80_0000;
        s[2] = 32'h40A0_0000;
        s[7] = 32'h40A0_0000;
        run_frame("tie", s, 2);

        for (int i = 0; i < NUM_CLASSES; i++) s[i] = (i % 2) ? 32'hC000_0000 : 32'hBF80_0000;
        s[4] = 32'h0000_0000;
        s[1] = 32'h8000_0000;
        run_frame("zeros", s, 1);

        for (int i = 0; i < NUM_CLASSES; i++) s[i] = 32'h4120_0000 + 32'(i);
        s[0] = 32'h7FC0_0000;
        s[5] = 32'h7F80_0000;
        run_frame("naninf", s, 5);

        for (int i = 0; i < NUM_CLASSES; i++) s[i] = 32'h7FC0_0000 | 32'(i);
        run_frame("allnan", s, 0);

        for (int i = 0; i < NUM_CLASSES; i++) s[i] = 32'h7FC0_0000;
        s[3] = 32'hC2C8_0000;
        s[6] = 32'hC2C8_0000;
        run_frame("nanlead", s, 3);

        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < NUM_CLASSES; i++) s[i] = rand_score();
            run_frame($sformatf("rand%0d", k), s, -1);
        end

        // Second input_valid mid-scan must be dropped.
        for (int i = 0; i < NUM_CLASSES; i++) t[i] = 32'h4000_0000;
        nov = 0;
        ov_at[0] = -1;
        @(negedge clk);
        drive(tenths);
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            bus.input_valid = 1'b0;
            if (c == 4) drive(t);
            if (bus.output_valid) begin
                nov++;
                if (ov_at[0] < 0) ov_at[0] = c;
            end
        end
        chk("midscan.pulses",  32'(nov),           32'd1);
        chk("midscan.latency", 32'(ov_at[0]),      32'd11);
        chk("midscan.class",   32'(bus.class_out), 32'd9);

        // input_valid in the DONE cycle starts the next frame immediately.
        for (int i = 0; i < NUM_CLASSES; i++) t[i] = 32'h3F80_0000;
        t[2] = 32'h40A0_0000;
        t[7] = 32'h40A0_0000;
        nov = 0;
        ov_at = '{-1, -1};
        @(negedge clk);
        drive(tenths);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            bus.input_valid = 1'b0;
            if (c == 10) begin
                chk("b2b.done_busy", 32'(bus.busy), 32'd0);
                drive(t);
            end
            if (bus.output_valid) begin
                if (nov < 2) ov_at[nov] = c;
                nov++;
                if (c == 11) chk("b2b.class0", 32'(bus.class_out), 32'd9);
                if (c == 21) chk("b2b.class1", 32'(bus.class_out), 32'd2);
            end
        end
        chk("b2b.pulses", 32'(nov),      32'd2);
        chk("b2b.first",  32'(ov_at[0]), 32'd11);
        chk("b2b.second", 32'(ov_at[1]), 32'd21);

        // Reset in scan cycle 4 aborts the frame with no result.
        nov = 0;
        @(negedge clk);
        drive(tenths);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.input_valid = 1'b0;
            if (c == 4) rst = 1'b1;
            if (c == 5) rst = 1'b0;
            if (bus.output_valid) nov++;
        end
        chk("abort.pulses", 32'(nov),           32'd0);
        chk("abort.class",  32'(bus.class_out), 32'd0);
        chk("abort.busy",   32'(bus.busy),      32'd0);
`ifdef ARGMAX_SCORE_OUT_EN
        chk("abort.score",  bus.max_score,      32'd0);
`endif

        run_frame("after_abort", tenths, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
